// File: rtl/pwm_disp_pkg.sv
// Shared types and constants for the PWM display controller: FSM states,
// selection modes, the blank digit code and the digit formatting helper.
package pwm_disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_FMT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'b00,
        MODE_SRC0   = 2'b01,
        MODE_SRC1   = 2'b10,
        MODE_FREEZE = 2'b11
    } sel_mode_t;

    localparam logic [3:0] BLANK_CODE = 4'hA;
    localparam int         MAX_DISP   = 9999;

    // Overflow blanks everything; otherwise blank leading zeros but always keep digit 0.
    function automatic logic [15:0] fmt_digits(input logic [15:0] bcd,
                                               input logic        over,
                                               input logic [3:0]  blank);
        logic [15:0] d;
        d = bcd;
        if (over) begin
            d = {4{blank}};
        end else if (bcd[15:12] == 4'd0) begin
            d[15:12] = blank;
            if (bcd[11:8] == 4'd0) begin
                d[11:8] = blank;
                if (bcd[7:4] == 4'd0) begin
                    d[7:4] = blank;
                end
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/pwm_display_ctrl_if.sv
// Signal bundle between the PWM core registers, the display controller and
// the seven-segment driver inputs.
interface pwm_display_ctrl_if #(
    parameter int W = 14
);
    logic [W-1:0] duty_val;
    logic [W-1:0] freq_val;
    logic [1:0]   sel_mode;
    logic         upd;
    logic [3:0]   digit0;
    logic [3:0]   digit1;
    logic [3:0]   digit2;
    logic [3:0]   digit3;
    logic         src_id;
    logic         busy;
    logic         ovf;

    modport master (
        output duty_val, freq_val, sel_mode, upd,
        input  digit0, digit1, digit2, digit3, src_id, busy, ovf
    );

    modport slave (
        input  duty_val, freq_val, sel_mode, upd,
        output digit0, digit1, digit2, digit3, src_id, busy, ovf
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: W iterations after start,
// done is high during the final shift cycle and bcd is valid the cycle after.
module bin2bcd_seq #(
    parameter int W = 14
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         done,
    output logic [15:0]  bcd
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  bin_q;
    logic [15:0]   bcd_q;
    logic [15:0]   bcd_adj;
    logic [CW-1:0] cnt_q;
    logic          active_q;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign done = active_q && (cnt_q == CW'(W - 1));
    assign bcd  = bcd_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            bin_q    <= bin;
            bcd_q    <= '0;
        end else if (active_q) begin
            bcd_q    <= {bcd_adj[14:0], bin_q[W-1]};
            bin_q    <= {bin_q[W-2:0], 1'b0};
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pwm_display_ctrl.sv
// Chooses which PWM quantity (duty or period) is displayed, converts it to
// BCD and drives four blank-suppressed digit codes to the seven-segment driver.
//
// state | meaning
// IDLE  | waiting for upd, refresh or source-change trigger (or pending)
// LOAD  | latch selected source value, start BCD engine
// SHIFT | W shift-add-3 iterations in bin2bcd_seq
// FMT   | overflow check, leading-zero blanking, register outputs
module pwm_display_ctrl
    import pwm_disp_pkg::*;
#(
    parameter int         W           = 14,
    parameter int         HOLD_CYC    = 100_000_000,
    parameter int         REFRESH_CYC = 5_000_000,
    parameter logic [3:0] BLANK       = BLANK_CODE
) (
    input logic               clock,
    input logic               reset,
    pwm_display_ctrl_if.slave bus
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    state_t         state_q, state_d;
    sel_mode_t      mode, mode_q;
    logic [HW-1:0]  hold_cnt_q;
    logic [RW-1:0]  ref_cnt_q;
    logic           sel_src_q;
    logic           src_q;
    logic           pending_q;
    logic [W-1:0]   val_q;
    logic [W-1:0]   sel_val;
    logic [15:0]    digits_q;
    logic           src_id_q;
    logic           ovf_q;

    logic           frozen, forced, forced_src;
    logic           hold_hit, ref_hit, src_chg, trig;
    logic           start, done, over;
    logic [15:0]    bcd;

    assign mode       = sel_mode_t'(bus.sel_mode);
    assign frozen     = (mode == MODE_FREEZE);
    assign forced     = (mode == MODE_SRC0) || (mode == MODE_SRC1);
    assign forced_src = (mode == MODE_SRC1);

    // A hold expiry only counts once the mode has been stable for a cycle.
    assign hold_hit = (mode == MODE_AUTO) && (mode == mode_q)
                   && (hold_cnt_q == HW'(HOLD_CYC - 1));
    assign ref_hit  = !frozen && (ref_cnt_q == RW'(REFRESH_CYC - 1));
    assign src_chg  = hold_hit || (forced && (forced_src != sel_src_q));
    assign trig     = bus.upd || ref_hit || src_chg;

    assign sel_val  = sel_src_q ? bus.freq_val : bus.duty_val;
    assign start    = (state_q == S_LOAD);
    assign over     = (32'(val_q) > 32'(MAX_DISP));

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q     <= MODE_AUTO;
            hold_cnt_q <= '0;
            ref_cnt_q  <= '0;
            sel_src_q  <= 1'b0;
        end else begin
            mode_q <= mode;
            if (mode != mode_q) begin
                hold_cnt_q <= '0;
            end else if (mode == MODE_AUTO) begin
                hold_cnt_q <= hold_hit ? '0 : hold_cnt_q + 1'b1;
            end
            if (ref_hit) begin
                ref_cnt_q <= '0;
            end else if (!frozen) begin
                ref_cnt_q <= ref_cnt_q + 1'b1;
            end
            if (hold_hit) begin
                sel_src_q <= ~sel_src_q;
            end else if (forced) begin
                sel_src_q <= forced_src;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if ((trig || pending_q) && !frozen) state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (done) state_d = S_FMT;
            S_FMT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Any trigger not consumed by an IDLE->LOAD transition collapses into one pending request.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= 1'b0;
            val_q     <= '0;
            src_q     <= 1'b0;
            digits_q  <= {4{BLANK}};
            src_id_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (state_q == S_IDLE && !frozen) begin
                pending_q <= 1'b0;
            end else if (trig) begin
                pending_q <= 1'b1;
            end
            if (start) begin
                val_q <= sel_val;
                src_q <= sel_src_q;
            end
            if (state_q == S_FMT) begin
                digits_q <= fmt_digits(bcd, over, BLANK);
                ovf_q    <= over;
                src_id_q <= src_q;
            end
        end
    end

    bin2bcd_seq #(
        .W (W)
    ) u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bin   (sel_val),
        .done  (done),
        .bcd   (bcd)
    );

    assign bus.digit0 = digits_q[3:0];
    assign bus.digit1 = digits_q[7:4];
    assign bus.digit2 = digits_q[11:8];
    assign bus.digit3 = digits_q[15:12];
    assign bus.src_id = src_id_q;
    assign bus.ovf    = ovf_q;
    assign bus.busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_pwm_display_ctrl.sv
// Directed bench for pwm_display_ctrl with short hold/refresh periods.
module tb_pwm_display_ctrl;

    localparam int W = 14;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   conv_cnt = 0;
    int   c0;
    logic busy_prev = 1'b0;

    always #5 clock = ~clock;

    pwm_display_ctrl_if #(.W(W)) bus ();

    pwm_display_ctrl #(
        .W           (W),
        .HOLD_CYC    (50),
        .REFRESH_CYC (1000),
        .BLANK       (4'hA)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Conversion counter: one per rising edge of busy.
    always @(posedge clock) begin
        #1;
        if (bus.busy === 1'b1 && busy_prev !== 1'b1) conv_cnt++;
        busy_prev = bus.busy;
    end

    function automatic logic [15:0] digs();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_upd();
        bus.upd = 1'b1;
        @(negedge clock);
        bus.upd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    // Pulse upd, confirm busy through the window and the result W+2 cycles on.
    task automatic conv_check(input string tag, input logic [15:0] exp_d,
                              input logic exp_src, input logic exp_ovf);
        pulse_upd();
        repeat (15) @(negedge clock);
        chk({tag, "_busy_last"}, bus.busy, 1'b1);
        @(negedge clock);
        chk({tag, "_digits"}, digs(), exp_d);
        chk({tag, "_src"}, bus.src_id, exp_src);
        chk({tag, "_ovf"}, bus.ovf, exp_ovf);
        chk({tag, "_busy_done"}, bus.busy, 1'b0);
    endtask

    initial begin
        bus.duty_val = '0;
        bus.freq_val = '0;
        bus.sel_mode = 2'b01;
        bus.upd      = 1'b0;
        do_reset();
        chk("rst_digits", digs(), 16'hAAAA);
        chk("rst_src", bus.src_id, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ovf", bus.ovf, 1'b0);

        // Forced source 0 with full latency check
        bus.duty_val = 14'd1234;
        pulse_upd();
        chk("f0_busy_first", bus.busy, 1'b1);
        chk("f0_hold_old", digs(), 16'hAAAA);
        repeat (15) @(negedge clock);
        chk("f0_busy_last", bus.busy, 1'b1);
        chk("f0_still_old", digs(), 16'hAAAA);
        @(negedge clock);
        chk("f0_digits", digs(), 16'h1234);
        chk("f0_src", bus.src_id, 1'b0);
        chk("f0_ovf", bus.ovf, 1'b0);
        chk("f0_busy_done", bus.busy, 1'b0);

        // Leading-zero blanking
        bus.duty_val = 14'd7;
        conv_check("lz7", 16'hAAA7, 1'b0, 1'b0);
        bus.duty_val = 14'd0;
        conv_check("lz0", 16'hAAA0, 1'b0, 1'b0);
        bus.duty_val = 14'd105;
        conv_check("lz105", 16'hA105, 1'b0, 1'b0);

        // Overflow; mode switch and upd in the same cycle give one conversion
        c0 = conv_cnt;
        bus.sel_mode = 2'b10;
        bus.freq_val = 14'd12000;
        conv_check("ovf", 16'hAAAA, 1'b1, 1'b1);
        repeat (20) @(negedge clock);
        chk("ovf_one_conv", conv_cnt - c0, 1);

        // Reset in the middle of a conversion
        bus.freq_val = 14'd321;
        pulse_upd();
        repeat (4) @(negedge clock);
        bus.sel_mode = 2'b11;
        do_reset();
        chk("rmid_digits", digs(), 16'hAAAA);
        chk("rmid_busy", bus.busy, 1'b0);
        chk("rmid_ovf", bus.ovf, 1'b0);
        chk("rmid_src", bus.src_id, 1'b0);
        c0 = conv_cnt;
        repeat (30) @(negedge clock);
        chk("rmid_no_late_digits", digs(), 16'hAAAA);
        chk("rmid_no_late_conv", conv_cnt - c0, 0);

        // Largest displayable value
        bus.sel_mode = 2'b10;
        bus.freq_val = 14'd9999;
        conv_check("max", 16'h9999, 1'b1, 1'b0);

        // Pending collapse: three upd pulses while busy -> one extra conversion
        bus.sel_mode = 2'b01;
        bus.duty_val = 14'd42;
        do_reset();
        c0 = conv_cnt;
        pulse_upd();
        repeat (2) @(negedge clock);
        bus.duty_val = 14'd43;
        pulse_upd();
        @(negedge clock);
        pulse_upd();
        @(negedge clock);
        pulse_upd();
        repeat (8) @(negedge clock);
        chk("pend_busy_last", bus.busy, 1'b1);
        chk("pend_still_old", digs(), 16'hAAAA);
        @(negedge clock);
        chk("pend_first", digs(), 16'hAA42);
        repeat (16) @(negedge clock);
        chk("pend_second_not_yet", digs(), 16'hAA42);
        @(negedge clock);
        chk("pend_second", digs(), 16'hAA43);
        repeat (26) @(negedge clock);
        chk("pend_conv_count", conv_cnt - c0, 2);

        // Freeze: value change and upd are held off until the mode leaves 11
        c0 = conv_cnt;
        bus.sel_mode = 2'b11;
        bus.duty_val = 14'd77;
        repeat (3) @(negedge clock);
        pulse_upd();
        repeat (30) @(negedge clock);
        chk("frz_digits", digs(), 16'hAA43);
        chk("frz_busy", bus.busy, 1'b0);
        chk("frz_no_conv", conv_cnt - c0, 0);
        bus.sel_mode = 2'b01;
        repeat (16) @(negedge clock);
        chk("frz_rel_busy", bus.busy, 1'b1);
        chk("frz_rel_old", digs(), 16'hAA43);
        @(negedge clock);
        chk("frz_rel_digits", digs(), 16'hAA77);
        chk("frz_rel_src", bus.src_id, 1'b0);
        chk("frz_rel_conv", conv_cnt - c0, 1);

        // Auto-rotate: source toggles every 50 cycles, shown 16 cycles later
        bus.sel_mode = 2'b00;
        bus.duty_val = 14'd11;
        bus.freq_val = 14'd22;
        do_reset();
        repeat (65) @(negedge clock);
        chk("auto1_pre", digs(), 16'hAAAA);
        chk("auto1_busy", bus.busy, 1'b1);
        @(negedge clock);
        chk("auto1_digits", digs(), 16'hAA22);
        chk("auto1_src", bus.src_id, 1'b1);
        repeat (49) @(negedge clock);
        chk("auto2_pre", digs(), 16'hAA22);
        @(negedge clock);
        chk("auto2_digits", digs(), 16'hAA11);
        chk("auto2_src", bus.src_id, 1'b0);
        repeat (49) @(negedge clock);
        chk("auto3_pre", digs(), 16'hAA11);
        @(negedge clock);
        chk("auto3_digits", digs(), 16'hAA22);
        chk("auto3_src", bus.src_id, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pwm_display_ctrl.md
Name: pwm_display_ctrl

Overview:
- Controller that feeds the 4-digit multiplexed seven-segment driver: it decides which PWM quantity is shown and produces the four digit codes.
- Arbitrates between two sources, duty value (source 0) and period/frequency value (source 1). Selection is forced or auto-rotated.
- Converts the selected binary value to BCD with a sequential shift-add-3 engine and blanks leading zeros.
- Sits between the PWM core registers and the seven-segment driver's in0..in3 inputs.

Parameters:
- W, 14, binary width of each source value (max displayable 9999).
- HOLD_CYC, 100000000, clock cycles each source is shown in auto-rotate mode (1 s at 100 MHz).
- REFRESH_CYC, 5000000, clock cycles between automatic re-samples of the current source.
- BLANK, 4'hA, digit code driven for blank or dash (driver shows segments off, dp on, for codes >= 10).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- duty_val  in  W  source 0 binary value
- freq_val  in  W  source 1 binary value
- sel_mode  in  2  00 auto-rotate, 01 force source 0, 10 force source 1, 11 freeze (no new conversions)
- upd  in  1  single-cycle strobe: request immediate re-sample of the current source
- digit0  out  4  least significant digit code (to driver in0)
- digit1  out  4  digit code (to in1)
- digit2  out  4  digit code (to in2)
- digit3  out  4  most significant digit code (to in3)
- src_id  out  1  source whose value is currently displayed
- busy  out  1  high while a conversion is in progress
- ovf  out  1  high when the displayed sample exceeded 9999

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: digit0..3 = BLANK, src_id = 0, busy = 0, ovf = 0. FSM goes to IDLE; hold, refresh and pending state are cleared.
- Reset during a conversion aborts it. Nothing from the aborted conversion reaches the outputs.
- FSM states: IDLE, LOAD, SHIFT, FMT.
  - IDLE -> LOAD when a trigger is present and sel_mode != 11.
  - LOAD: latch the selected source value; clear the BCD accumulator and shift count; busy = 1.
  - SHIFT: exactly W cycles. Each cycle, every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1.
  - FMT: apply overflow check and leading-zero blanking, register the outputs, go to IDLE; busy = 0 in IDLE.
- Latency: trigger seen in IDLE -> outputs updated W+2 cycles later. For W=14 that is 16 cycles. Outputs hold their value throughout a conversion.
- Triggers:
  - upd strobe.
  - Refresh counter reaching REFRESH_CYC-1 (counter then wraps to 0).
  - Source change (auto-rotate hold expiry, or sel_mode switched to a different forced source).
- Trigger arriving while busy sets a single pending flag. Pending is serviced on the return to IDLE. Multiple triggers while busy collapse into one.
- Source selection:
  - Modes 01 and 10 select source 0 and 1 respectively.
  - In mode 00 the hold counter counts to HOLD_CYC-1, then the source toggles and a trigger is raised.
  - The hold counter resets to 0 whenever the mode changes.
  - Mode 11 freezes outputs, src_id, and the hold/refresh counters. Pending is kept and serviced when the mode leaves 11.
- src_id updates in FMT, together with the digits, so it always matches the displayed digits.
- Overflow: if the latched value > 9999, all four digits = BLANK and ovf = 1. Otherwise ovf = 0.
- Blanking: digit3, then digit2, then digit1 are set to BLANK while they are zero and all higher digits are zero. digit0 always shows its value, so 0 displays as "   0".
- Simultaneous upd and source-change in the same cycle produce one conversion, using the new source.
- Source values are sampled only in LOAD. Changes during SHIFT have no effect.

Decomposition:
- Shared package pwm_disp_pkg: FSM state encoding, BLANK code, sel_mode encodings, MAX_DISP = 9999.
- One natural sub-module: bin2bcd_seq, the W-iteration shift-add-3 engine.
  - Ports: start, bin[W-1:0], done, bcd[15:0].
  - The parent keeps arbitration, timers and formatting.

Test Plan:
- Reset: hold reset 3 cycles mid-conversion -> digits all 4'hA, busy 0, ovf 0, and no late update afterwards.
- Force source 0: sel_mode=01, duty_val=1234, pulse upd -> 16 cycles later digit3..0 = 1,2,3,4; src_id 0; busy high for exactly the conversion window.
- Leading zeros and zero: duty_val=7 -> digits A,A,A,7. duty_val=0 -> A,A,A,0. duty_val=105 -> A,1,0,5.
- Overflow: freq_val=12000, sel_mode=10, upd -> digits A,A,A,A; ovf 1; src_id 1. Then freq_val=9999, upd -> 9,9,9,9 and ovf 0.
- Auto-rotate (HOLD_CYC=50, REFRESH_CYC=1000): duty=11, freq=22 -> display alternates 11/22 every 50 cycles, src_id toggling in step with the digits.
- Pending collapse and freeze:
  - Three upd pulses during one conversion -> exactly two conversions in total.
  - sel_mode=11 with a value change -> outputs unchanged. Returning to 01 services the pending request.
